// File: rtl/hm_kbd_pkg.sv
// Shared keyboard definitions: receive/decoder state encodings, PS/2 set-2
// prefix bytes, the USB-HID usage codes the game logic consumes, and the
// frame parity helper.
package hm_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } dec_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_UP    = 8'h52;

    // Odd parity across data byte plus parity bit: total number of ones is odd.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_scan_to_hid.sv
// Combinational set-2 scan code to USB-HID usage lookup.
// Ports:
//   code   - set-2 scan code byte (prefixes already stripped)
//   ext    - 1 when the code was preceded by the E0 prefix
//   hid    - HID usage code, HID_NONE when unmapped
//   mapped - 1 when the (code, ext) pair has a HID translation
module ps2_scan_to_hid
    import hm_kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] hid,
    output logic       mapped
);

    // Table lookup; letters and Enter only exist unprefixed, arrows only with E0.
    always_comb begin
        hid    = HID_NONE;
        mapped = 1'b1;
        if (ext) begin
            case (code)
                8'h74:   hid = HID_RIGHT;
                8'h6B:   hid = HID_LEFT;
                8'h72:   hid = HID_DOWN;
                8'h75:   hid = HID_UP;
                default: mapped = 1'b0;
            endcase
        end else begin
            case (code)
                8'h1C:   hid = 8'h04; // a
                8'h32:   hid = 8'h05; // b
                8'h21:   hid = 8'h06; // c
                8'h23:   hid = 8'h07; // d
                8'h24:   hid = 8'h08; // e
                8'h2B:   hid = 8'h09; // f
                8'h34:   hid = 8'h0A; // g
                8'h33:   hid = 8'h0B; // h
                8'h43:   hid = 8'h0C; // i
                8'h3B:   hid = 8'h0D; // j
                8'h42:   hid = 8'h0E; // k
                8'h4B:   hid = 8'h0F; // l
                8'h3A:   hid = 8'h10; // m
                8'h31:   hid = 8'h11; // n
                8'h44:   hid = 8'h12; // o
                8'h4D:   hid = 8'h13; // p
                8'h15:   hid = 8'h14; // q
                8'h2D:   hid = 8'h15; // r
                8'h1B:   hid = 8'h16; // s
                8'h2C:   hid = 8'h17; // t
                8'h3C:   hid = 8'h18; // u
                8'h2A:   hid = 8'h19; // v
                8'h1D:   hid = 8'h1A; // w
                8'h22:   hid = 8'h1B; // x
                8'h35:   hid = 8'h1C; // y
                8'h1A:   hid = 8'h1D; // z
                8'h5A:   hid = HID_ENTER;
                default: mapped = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver that drives a level-style HID keycode.
// Ports:
//   Clk       - system clock (50 MHz)
//   Reset     - asynchronous active-low reset
//   ps2_clk   - raw PS/2 clock, asynchronous
//   ps2_data  - raw PS/2 data, asynchronous
//   keycode   - HID code of the held key, 0x00 when none
//   key_valid - one-cycle pulse whenever keycode changes
//   frame_err - one-cycle pulse on parity error, stop error or timeout
module ps2_keycode_rx
    import hm_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

    logic [1:0]     clk_sync_r, data_sync_r;
    logic [FCW-1:0] filt_cnt_r;
    logic           filt_r, filt_d_r;
    logic           sample_s, din_s;

    rx_state_t      rx_state_r, rx_state_s;
    logic [2:0]     bit_cnt_r, bit_cnt_s;
    logic [7:0]     shift_r, shift_s;
    logic           parity_r, parity_s;
    logic [TCW-1:0] to_cnt_r, to_cnt_s;
    logic           timeout_s, byte_valid_s, rx_err_s;
    logic           byte_valid_r;
    logic [7:0]     byte_r;
    logic           frame_err_r;

    dec_state_t     dec_state_r, dec_state_s;
    logic [7:0]     keycode_r, keycode_s;
    logic           key_valid_r;
    logic           dec_ext_s, map_hit_s;
    logic [7:0]     map_hid_s;

    // Two-flop synchronizers; idle PS/2 lines are high.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN disagreeing samples.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            filt_cnt_r <= '0;
            filt_r     <= 1'b1;
            filt_d_r   <= 1'b1;
        end else begin
            filt_d_r <= filt_r;
            if (clk_sync_r[1] == filt_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FILT_LAST) begin
                filt_r     <= clk_sync_r[1];
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FCW'(1);
            end
        end
    end

    assign sample_s  = filt_d_r & ~filt_r;
    assign din_s     = data_sync_r[1];
    assign timeout_s = (rx_state_r != IDLE) && (to_cnt_r == TO_LAST);

    // Receive FSM next state: frame bit sequencing, validity check, timeout.
    always_comb begin
        rx_state_s   = rx_state_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        parity_s     = parity_r;
        byte_valid_s = 1'b0;
        rx_err_s     = 1'b0;
        if (rx_state_r == IDLE || sample_s) begin
            to_cnt_s = '0;
        end else begin
            to_cnt_s = to_cnt_r + TCW'(1);
        end
        case (rx_state_r)
            IDLE: begin
                if (sample_s && !din_s) begin
                    rx_state_s = DATA;
                    bit_cnt_s  = 3'd0;
                end else begin
                    rx_state_s = IDLE;
                end
            end
            DATA: begin
                if (timeout_s) begin
                    rx_state_s = IDLE;
                    rx_err_s   = 1'b1;
                end else if (sample_s) begin
                    shift_s   = {din_s, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        rx_state_s = PARITY;
                    end else begin
                        rx_state_s = DATA;
                    end
                end else begin
                    rx_state_s = DATA;
                end
            end
            PARITY: begin
                if (timeout_s) begin
                    rx_state_s = IDLE;
                    rx_err_s   = 1'b1;
                end else if (sample_s) begin
                    parity_s   = din_s;
                    rx_state_s = STOP;
                end else begin
                    rx_state_s = PARITY;
                end
            end
            STOP: begin
                if (timeout_s) begin
                    rx_state_s = IDLE;
                    rx_err_s   = 1'b1;
                end else if (sample_s) begin
                    rx_state_s = IDLE;
                    if (din_s && odd_parity_ok({shift_r, parity_r})) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        rx_err_s = 1'b1;
                    end
                end else begin
                    rx_state_s = STOP;
                end
            end
            default: begin
                rx_state_s = IDLE;
            end
        endcase
    end

    // Receive FSM state, datapath registers and delivery/error strobes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rx_state_r   <= IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            parity_r     <= 1'b0;
            to_cnt_r     <= '0;
            byte_valid_r <= 1'b0;
            byte_r       <= 8'h00;
            frame_err_r  <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            parity_r     <= parity_s;
            to_cnt_r     <= to_cnt_s;
            byte_valid_r <= byte_valid_s;
            byte_r       <= shift_r;
            frame_err_r  <= rx_err_s;
        end
    end

    assign dec_ext_s = (dec_state_r == EXT) || (dec_state_r == EXTBRK);

    ps2_scan_to_hid u_map (
        .code   (byte_r),
        .ext    (dec_ext_s),
        .hid    (map_hid_s),
        .mapped (map_hit_s)
    );

    // Decoder FSM: prefix tracking, make/break application to the held key.
    always_comb begin
        dec_state_s = dec_state_r;
        keycode_s   = keycode_r;
        if (frame_err_r) begin
            dec_state_s = NORMAL;
        end else if (byte_valid_r) begin
            case (dec_state_r)
                NORMAL: begin
                    if (byte_r == PS2_EXT) begin
                        dec_state_s = EXT;
                    end else if (byte_r == PS2_BRK) begin
                        dec_state_s = BRK;
                    end else if (map_hit_s) begin
                        keycode_s = map_hid_s;
                    end else begin
                        dec_state_s = NORMAL;
                    end
                end
                EXT: begin
                    if (byte_r == PS2_BRK) begin
                        dec_state_s = EXTBRK;
                    end else begin
                        dec_state_s = NORMAL;
                        if (map_hit_s) begin
                            keycode_s = map_hid_s;
                        end else begin
                            keycode_s = keycode_r;
                        end
                    end
                end
                BRK, EXTBRK: begin
                    dec_state_s = NORMAL;
                    // Only releasing the key currently shown clears the output.
                    if (map_hit_s && (map_hid_s == keycode_r)) begin
                        keycode_s = HID_NONE;
                    end else begin
                        keycode_s = keycode_r;
                    end
                end
                default: begin
                    dec_state_s = NORMAL;
                end
            endcase
        end else begin
            dec_state_s = dec_state_r;
        end
    end

    // Decoder state and registered outputs; key_valid marks any value change.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dec_state_r <= NORMAL;
            keycode_r   <= HID_NONE;
            key_valid_r <= 1'b0;
        end else begin
            dec_state_r <= dec_state_s;
            keycode_r   <= keycode_s;
            key_valid_r <= (keycode_s != keycode_r);
        end
    end

    assign keycode   = keycode_r;
    assign key_valid = key_valid_r;
    assign frame_err = frame_err_r;

endmodule
